// File: rtl/mem_pkg.sv
// Shared types for the MEM pipeline stage: LSU opcodes, FSM states, result selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    // Load/store width and extension selector; stores only look at bits [1:0]
    typedef enum logic [2:0] {
        LSU_B  = 3'b000,
        LSU_H  = 3'b001,
        LSU_W  = 3'b010,
        LSU_BU = 3'b100,
        LSU_HU = 3'b101
    } lsu_op_e;

    // Data-memory access sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } mem_state_e;

    // Writeback result select encodings
    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Contents of the M/W pipeline register
    typedef struct packed {
        logic        insn_vld;
        logic        reg_write;
        logic [1:0]  result_src;
        logic [4:0]  rd_addr;
        logic [31:0] pc_plus4;
        logic [31:0] alu_result;
        logic [31:0] read_data;
    } mw_reg_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, extraction/extension for loads, alignment check.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  lsu_op,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] ld_data,
    output logic        misalign
);

    logic [31:0] shifted;

    // Store lanes and misalignment depend only on the access size in bits [1:0]
    always_comb begin
        be       = 4'b1111;
        wdata    = st_data;
        misalign = 1'b0;
        case (lsu_op[1:0])
            2'b00: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                be       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata    = {2{st_data[15:0]}};
                misalign = addr_lo[0];
            end
            default: begin
                misalign = |addr_lo;
            end
        endcase
    end

    // Bring the addressed bytes down to bit 0, then sign- or zero-extend
    always_comb begin
        shifted = ld_word >> {addr_lo, 3'b000};
        ld_data = shifted;
        case (lsu_op_e'(lsu_op))
            LSU_B:   ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LSU_BU:  ld_data = {24'h0, shifted[7:0]};
            LSU_H:   ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LSU_HU:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// MEM stage: drives the data-memory req/gnt/rvalid port and holds the M/W register.
// Latency: 1 cycle for non-memory ops and granted stores; loads take 2 + memory wait cycles.
// Backpressure: StallM freezes upstream while an access is pending; W receives bubbles meanwhile.
module memory_cycle
    import mem_pkg::*;
#(
    parameter int DMEM_AW      = 32,
    parameter int RESP_TIMEOUT = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               insn_vldM,
    input  logic               RegWriteM,
    input  logic               MemWriteM,
    input  logic [1:0]         ResultSrcM,
    input  logic [2:0]         LsuOpM,
    input  logic [4:0]         RD_ADDR_M,
    input  logic [31:0]        PCPlus4M,
    input  logic [31:0]        ALU_ResultM,
    input  logic [31:0]        WriteDataM,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [DMEM_AW-1:0] o_dmem_addr,
    output logic [3:0]         o_dmem_be,
    output logic [31:0]        o_dmem_wdata,
    input  logic               i_dmem_gnt,
    input  logic               i_dmem_rvalid,
    input  logic [31:0]        i_dmem_rdata,
    output logic               StallM,
    output logic               MisalignM,
    output logic               ErrM,
    output logic               insn_vldW,
    output logic               RegWriteW,
    output logic [1:0]         ResultSrcW,
    output logic [4:0]         RD_ADDR_W,
    output logic [31:0]        PCPlus4W,
    output logic [31:0]        ALU_ResultW,
    output logic [31:0]        ReadDataW
);

    localparam int CW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT + 1) : 1;

    mem_state_e    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    mw_reg_t       w_q, w_d;

    logic        is_access;
    logic        addr_misalign;
    logic [31:0] ld_ext;
    logic        timeout_hit;
    logic        req_c, stall_c, misalign_c, err_c, rd_capture;

    lsu_align u_align (
        .addr_lo  (ALU_ResultM[1:0]),
        .lsu_op   (LsuOpM),
        .st_data  (WriteDataM),
        .ld_word  (i_dmem_rdata),
        .be       (o_dmem_be),
        .wdata    (o_dmem_wdata),
        .ld_data  (ld_ext),
        .misalign (addr_misalign)
    );

    assign is_access   = insn_vldM & (MemWriteM | (ResultSrcM == RES_MEM));
    assign timeout_hit = (RESP_TIMEOUT > 0) && (wait_cnt_q == CW'(RESP_TIMEOUT));

    // Access sequencing: request, grant, response wait, timeout abort
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        misalign_c = 1'b0;
        err_c      = 1'b0;
        rd_capture = 1'b0;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (is_access) begin
                    if (addr_misalign) begin
                        misalign_c = 1'b1;
                    end else begin
                        req_c = 1'b1;
                        if (!i_dmem_gnt) begin
                            state_d = REQ;
                            stall_c = 1'b1;
                        end else if (!MemWriteM) begin
                            state_d = WAIT;
                            stall_c = 1'b1;
                        end
                    end
                end
            end
            REQ: begin
                // Upstream is frozen, so req/we/addr/be/wdata stay stable here
                req_c   = 1'b1;
                stall_c = 1'b1;
                if (i_dmem_gnt) begin
                    if (MemWriteM) begin
                        state_d = IDLE;
                        stall_c = 1'b0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (i_dmem_rvalid) begin
                    stall_c    = 1'b0;
                    rd_capture = 1'b1;
                    state_d    = IDLE;
                end else if (timeout_hit) begin
                    stall_c = 1'b0;
                    err_c   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // M/W register: capture on advance, insert a bubble while stalled
    always_comb begin
        w_d           = w_q;
        w_d.insn_vld  = 1'b0;
        w_d.reg_write = 1'b0;
        if (!stall_c) begin
            w_d.insn_vld   = insn_vldM;
            w_d.reg_write  = RegWriteM & ~misalign_c & ~err_c;
            w_d.result_src = ResultSrcM;
            w_d.rd_addr    = RD_ADDR_M;
            w_d.pc_plus4   = PCPlus4M;
            w_d.alu_result = ALU_ResultM;
            w_d.read_data  = rd_capture ? ld_ext : 32'h0;
        end
    end

    // State, wait counter and M/W register flops
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            w_q        <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            w_q        <= w_d;
        end
    end

    // Reset masks the combinational strobes so req drops the instant reset asserts
    assign o_dmem_req  = req_c & ~i_rst;
    assign StallM      = stall_c & ~i_rst;
    assign MisalignM   = misalign_c & ~i_rst;
    assign ErrM        = err_c & ~i_rst;
    assign o_dmem_we   = MemWriteM;
    assign o_dmem_addr = {ALU_ResultM[DMEM_AW-1:2], 2'b00};

    assign insn_vldW   = w_q.insn_vld;
    assign RegWriteW   = w_q.reg_write;
    assign ResultSrcW  = w_q.result_src;
    assign RD_ADDR_W   = w_q.rd_addr;
    assign PCPlus4W    = w_q.pc_plus4;
    assign ALU_ResultW = w_q.alu_result;
    assign ReadDataW   = w_q.read_data;

endmodule

// File: tb/tb_memory_cycle.sv
// Self-checking bench for memory_cycle with a behavioural byte-addressed memory model.
// Latency: each instruction's stall length is predicted from its grant/response schedule.
// Backpressure: the bench plays the data memory, choosing grant and response delays.
module tb_memory_cycle;

    localparam int TO = 4;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        insn_vldM, RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  LsuOpM;
    logic [4:0]  RD_ADDR_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_gnt, i_dmem_rvalid;
    logic [31:0] i_dmem_rdata;
    logic        StallM, MisalignM, ErrM;
    logic        insn_vldW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_ADDR_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int checks = 0;
    int errors = 0;

    logic [31:0] dmem [64];
    logic [7:0]  ref_mem [256];
    logic [31:0] last_rdw, last_wdata;
    logic [3:0]  last_be;

    memory_cycle #(.DMEM_AW(32), .RESP_TIMEOUT(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .insn_vldM(insn_vldM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .LsuOpM(LsuOpM), .RD_ADDR_M(RD_ADDR_M),
        .PCPlus4M(PCPlus4M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .StallM(StallM), .MisalignM(MisalignM), .ErrM(ErrM),
        .insn_vldW(insn_vldW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RD_ADDR_W(RD_ADDR_W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
        .ReadDataW(ReadDataW)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        logic [7:0] ad;
        ad = a[7:0];
        b0 = ref_mem[ad];
        b1 = ref_mem[8'(ad + 8'd1)];
        b2 = ref_mem[8'(ad + 8'd2)];
        b3 = ref_mem[8'(ad + 8'd3)];
        case (op)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    task automatic preset_word(input logic [31:0] a, input logic [31:0] v);
        dmem[a[7:2]] = v;
        for (int i = 0; i < 4; i++) ref_mem[{a[7:2], 2'b00} + i] = v[8*i +: 8];
    endtask

    task automatic set_bubble();
        insn_vldM = 0; RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; LsuOpM = 0;
        RD_ADDR_M = 0; PCPlus4M = 0; ALU_ResultM = 0; WriteDataM = 0;
        i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = 0;
    endtask

    // One instruction: g = cycles until grant, r = cycles from grant to data (r > TO: never)
    task automatic run_insn(input logic vld, input logic rw, input logic mw, input logic [1:0] rs,
                            input logic [2:0] op, input logic [4:0] rd, input logic [31:0] pc4,
                            input logic [31:0] a, input logic [31:0] wd, input int g, input int r);
        logic        is_acc, is_ld, mis, tmo;
        int          n, done_k;
        logic [7:0]  be_w;
        logic [31:0] exp_wd, exp_rd, w;
        is_acc = vld && (mw || rs == 2'b01);
        is_ld  = is_acc && !mw;
        n      = (op[1:0] == 2'b00) ? 1 : (op[1:0] == 2'b01) ? 2 : 4;
        mis    = is_acc && ((int'(a[1:0]) % n) != 0);
        tmo    = is_ld && !mis && (r > TO);
        done_k = (!is_acc || mis) ? 0 : mw ? g : tmo ? g + 1 + TO : g + r;
        exp_rd = (is_ld && !mis && !tmo) ? ref_load(op, a) : 32'h0;
        be_w   = 8'(((1 << n) - 1) << a[1:0]);
        exp_wd = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;

        @(posedge i_clk); #1;
        insn_vldM = vld; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; LsuOpM = op;
        RD_ADDR_M = rd; PCPlus4M = pc4; ALU_ResultM = a; WriteDataM = wd;
        for (int k = 0; k <= done_k; k++) begin
            if (k > 0) begin @(posedge i_clk); #1; end
            i_dmem_gnt    = is_acc && !mis && (k == g);
            i_dmem_rvalid = (is_ld && !mis && !tmo && k == g + r) ? 1'b1 :
                            ((k < g) || !is_acc || mis) ? 1'($urandom_range(0, 1)) : 1'b0;
            i_dmem_rdata  = (is_ld && k == g + r) ? dmem[a[7:2]] : $urandom;
            @(negedge i_clk);
            chk("req", o_dmem_req, is_acc && !mis && k <= g);
            chk("stall", StallM, k < done_k);
            chk("misalign", MisalignM, mis && k == 0);
            chk("err", ErrM, tmo && k == done_k);
            if (k > 0) begin
                chk("stall_bubble_vld", insn_vldW, 0);
                chk("stall_bubble_rw", RegWriteW, 0);
            end
            if (is_acc && !mis && k <= g) begin
                chk("we", o_dmem_we, mw);
                chk("addr", o_dmem_addr, {a[31:2], 2'b00});
                if (mw) begin
                    chk("be", o_dmem_be, be_w[3:0]);
                    chk("wdata", o_dmem_wdata, exp_wd);
                    last_be = o_dmem_be;
                    last_wdata = o_dmem_wdata;
                    if (k == g) begin
                        w = dmem[a[7:2]];
                        for (int b = 0; b < 4; b++)
                            if (o_dmem_be[b]) w[8*b +: 8] = o_dmem_wdata[8*b +: 8];
                        dmem[a[7:2]] = w;
                    end
                end
            end
        end
        @(posedge i_clk); #1;
        set_bubble();
        @(negedge i_clk);
        chk("w_vld", insn_vldW, vld);
        chk("w_regwrite", RegWriteW, rw && !mis && !tmo);
        chk("w_ressrc", ResultSrcW, rs);
        chk("w_rd", RD_ADDR_W, rd);
        chk("w_pc4", PCPlus4W, pc4);
        chk("w_alu", ALU_ResultW, a);
        chk("w_rdata", ReadDataW, exp_rd);
        last_rdw = ReadDataW;
        if (mw && vld && !mis)
            for (int i = 0; i < n; i++) ref_mem[8'(a[7:0] + 8'(i))] = wd[8*i +: 8];
    endtask

    initial begin
        logic [31:0] a, wd;
        logic [2:0]  op;
        int          kind, g, r;

        for (int i = 0; i < 64; i++) preset_word(32'(i * 4), $urandom);
        set_bubble();
        i_rst = 1;
        @(negedge i_clk);
        chk("rst_req", o_dmem_req, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_mis", MisalignM, 0);
        chk("rst_err", ErrM, 0);
        chk("rst_w", {insn_vldW, RegWriteW, ResultSrcW, RD_ADDR_W}, 0);
        chk("rst_w_data", PCPlus4W | ALU_ResultW | ReadDataW, 0);
        @(posedge i_clk); #1;
        i_rst = 0;

        // SW with immediate grant
        run_insn(1, 0, 1, 2'b00, 3'b010, 5'd0, 32'h4, 32'h100, 32'hDEADBEEF, 0, 0);
        chk("sw_be", last_be, 4'b1111);
        // LB / LBU of 0x203 with grant after 2 cycles, data 1 cycle later
        preset_word(32'h200, 32'h80FF_0000);
        run_insn(1, 1, 0, 2'b01, 3'b000, 5'd3, 32'h8, 32'h203, 0, 2, 1);
        chk("lb_sext", last_rdw, 32'hFFFF_FF80);
        run_insn(1, 1, 0, 2'b01, 3'b100, 5'd4, 32'hC, 32'h203, 0, 2, 1);
        chk("lbu_zext", last_rdw, 32'h0000_0080);
        // SH upper half, then misaligned LH
        run_insn(1, 0, 1, 2'b00, 3'b001, 5'd0, 32'h10, 32'h12, 32'h0000ABCD, 1, 0);
        chk("sh_be", last_be, 4'b1100);
        chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
        run_insn(1, 1, 0, 2'b01, 3'b001, 5'd6, 32'h14, 32'h13, 0, 0, 1);
        // ALU and PC+4 results
        run_insn(1, 1, 0, 2'b00, 3'b000, 5'd7, 32'h18, 32'h55, 0, 0, 0);
        run_insn(1, 1, 0, 2'b10, 3'b000, 5'd8, 32'h1234_5678, 32'h99, 0, 0, 0);
        // Response timeout, then a normal load proves the FSM is idle again
        run_insn(1, 1, 0, 2'b01, 3'b010, 5'd9, 32'h20, 32'h40, 0, 0, 1000);
        run_insn(1, 1, 0, 2'b01, 3'b010, 5'd9, 32'h24, 32'h40, 0, 0, 2);

        // Reset while waiting for load data; late response must be ignored
        @(posedge i_clk); #1;
        insn_vldM = 1; RegWriteM = 1; ResultSrcM = 2'b01; LsuOpM = 3'b010;
        RD_ADDR_M = 5'd10; PCPlus4M = 32'h30; ALU_ResultM = 32'h44; i_dmem_gnt = 1;
        @(posedge i_clk); #1;
        i_dmem_gnt = 0;
        @(negedge i_clk);
        chk("wait_stall", StallM, 1);
        i_rst = 1; #1;
        chk("rst_wait_req", o_dmem_req, 0);
        chk("rst_wait_stall", StallM, 0);
        chk("rst_wait_w", {insn_vldW, RegWriteW, RD_ADDR_W}, 0);
        chk("rst_wait_rdata", ReadDataW, 0);
        @(posedge i_clk); #1;
        i_rst = 0;
        set_bubble();
        @(posedge i_clk); #1;
        i_dmem_rvalid = 1; i_dmem_rdata = 32'hCAFE_F00D;
        @(negedge i_clk);
        chk("late_rv_stall", StallM, 0);
        chk("late_rv_req", o_dmem_req, 0);
        @(posedge i_clk); #1;
        i_dmem_rvalid = 0;
        @(negedge i_clk);
        chk("late_rv_rdata", ReadDataW, 0);
        chk("late_rv_rw", RegWriteW, 0);

        // Reset while a request is pending drops req at once
        @(posedge i_clk); #1;
        insn_vldM = 1; ResultSrcM = 2'b01; LsuOpM = 3'b010; ALU_ResultM = 32'h48;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("req_state_req", o_dmem_req, 1);
        i_rst = 1; #1;
        chk("rst_req_drop", o_dmem_req, 0);
        @(posedge i_clk); #1;
        set_bubble();
        i_rst = 0;

        // Randomized instruction mix
        for (int i = 0; i < 200; i++) begin
            kind = $urandom_range(0, 9);
            a  = $urandom;
            wd = $urandom;
            g  = $urandom_range(0, 3);
            r  = $urandom_range(1, TO);
            case (kind)
                0: run_insn(1, 1, 0, 2'b00, 3'($urandom), 5'($urandom), $urandom, a, wd, 0, 0);
                1: run_insn(1, 1, 0, 2'b10, 3'($urandom), 5'($urandom), $urandom, a, wd, 0, 0);
                2, 3, 4, 5: begin
                    case ($urandom_range(0, 4))
                        0: op = 3'b000; 1: op = 3'b001; 2: op = 3'b010; 3: op = 3'b100;
                        default: op = 3'b101;
                    endcase
                    if ($urandom_range(0, 3) != 0) a[1:0] = (op[1:0] == 2'b00) ? a[1:0] :
                                                            (op[1:0] == 2'b01) ? {a[1], 1'b0} : 2'b00;
                    run_insn(1, 1, 0, 2'b01, op, 5'($urandom), $urandom, a, wd, g, r);
                end
                6, 7, 8: begin
                    op = 3'($urandom_range(0, 2));
                    if ($urandom_range(0, 3) != 0) a[1:0] = (op[1:0] == 2'b00) ? a[1:0] :
                                                            (op[1:0] == 2'b01) ? {a[1], 1'b0} : 2'b00;
                    run_insn(1, 0, 1, 2'b00, op, 5'($urandom), $urandom, a, wd, g, 0);
                end
                default: run_insn(0, 1'($urandom), 1'($urandom), 2'($urandom), 3'b010,
                                  5'($urandom), $urandom, a, wd, 0, 0);
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
